data_sram_bridge: RTL and testbench
===================================

Name: data_sram_bridge

Overview:
- Memory-stage data-side bridge, directly downstream of the datapath's M stage.
- Consumes the M-stage load/store request: address, decoded write data, per-byte read/write enables, size.
- Runs one transaction on the SRAM-like data bus (req/addr_ok, then data_ok) and returns read data to the datapath.
- Drives `stallreq_from_mem` into the hazard unit until the access completes, then holds the result until the pipeline advances.

Parameters:
- ADDR_W, 32, width of CPU and bus address.
- PADDR_MAP, 1, when 1 apply fixed kseg0/kseg1 mapping (clear addr[31:29] for 0x8000_0000–0xBFFF_FFFF); when 0 pass the address through.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- cpu_ren  in  4  byte read enables (readEnM).
- cpu_wen  in  4  byte write enables (writeEnM).
- cpu_addr  in  ADDR_W  virtual byte address (aluoutM).
- cpu_wdata  in  32  lane-aligned store data (writedata_decodedM).
- cpu_size  in  2  0=byte, 1=half, 2=word.
- cpu_flush  in  1  exception flush (flush_except).
- cpu_longest_stall  in  1  pipeline held by some other stall source.
- cpu_rdata  out  32  load data returned to the M stage.
- stallreq_from_mem  out  1  request that the hazard unit freeze F..M.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  copy of cpu_size.
- data_addr  out  ADDR_W  mapped physical address.
- data_wdata  out  32  store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid / write complete.
- data_rdata  in  32  bus read data.

Behaviour:
- access = |cpu_ren | |cpu_wen. If both enables are non-zero, the write wins (data_wr=1).
- FSM states: IDLE, ADDR, DATA, HOLD. Reset state IDLE, with killed=0 and rdata_q=0.
- Reset outputs: data_req=0, stallreq_from_mem=0, cpu_rdata=0, data_wr=0, data_addr=0, data_wdata=0, data_size=0.
- data_req = (IDLE & access & ~cpu_flush) | ADDR.
- Address, wr, size and wdata are registered at the IDLE->ADDR/DATA transition and held stable until addr_ok. In the IDLE request cycle they are driven combinationally from the cpu_* inputs.
- IDLE:
  - access & ~flush & addr_ok -> DATA.
  - access & ~flush & ~addr_ok -> ADDR.
  - Otherwise stay in IDLE.
- ADDR: addr_ok -> DATA. data_req is never withdrawn before addr_ok, even if flushed.
- DATA: data_ok -> HOLD if ~killed, else -> IDLE. rdata_q <= data_rdata on data_ok (captured on writes too; don't-care).
- HOLD: ~cpu_longest_stall -> IDLE; otherwise stay in HOLD.
- killed: set when cpu_flush=1 in ADDR or DATA; cleared on entry to IDLE. A killed transaction completes on the bus, its data is discarded, and it never enters HOLD.
- stallreq_from_mem = (IDLE & access & ~cpu_flush) | ADDR | DATA. It is 0 in HOLD so the pipeline can advance.
- cpu_rdata = rdata_q in HOLD, and data_rdata combinationally on the data_ok cycle.
- Minimum latency: req in cycle 0 with addr_ok, data_ok in cycle 1, HOLD in cycle 2 with stall=0. So a load costs 2 stall cycles.
- Bus rule (relied on): data_ok arrives at least one cycle after its addr_ok, and there is one outstanding transaction at most.
- Reset mid-transaction: the FSM returns to IDLE immediately. The bus side is reset with the core.

Optional Feature:
- Macro: DATA_SRAM_BRIDGE_PERF_EN.
- When defined: adds outputs perf_access_cnt[31:0] and perf_stall_cnt[31:0]. Both are reset to 0.
  - perf_access_cnt increments on every non-killed data_ok.
  - perf_stall_cnt increments each cycle stallreq_from_mem=1.
  - Both counters wrap modulo 2^32.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_mem_pkg:
  - state encoding (IDLE=0, ADDR=1, DATA=2, HOLD=3);
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD;
  - KSEG0_BASE/KSEG1_BASE constants.
- One sub-module, fixed_addr_map: purely combinational virtual-to-physical map controlled by PADDR_MAP, reusable by the instruction-side bridge.

Test Plan:
- Load, addr=0x8000_1004, ren=4'hF, addr_ok in cycle 0, data_ok=1 in cycle 2 with rdata=0xDEADBEEF:
  - data_addr=0x0000_1004, data_wr=0;
  - stall=1 in cycles 0–2, stall=0 in cycle 3 with cpu_rdata=0xDEADBEEF.
- Store byte, wen=4'b0100, addr=0xA000_0002, size=0, addr_ok delayed 3 cycles:
  - data_req=1 and address stable for cycles 0–3, data_wr=1, data_addr=0x0000_0002;
  - stall released only after data_ok.
- HOLD with longest_stall=1 for 4 cycles after data_ok:
  - FSM stays in HOLD and cpu_rdata is held constant;
  - no second data_req appears while the same load remains in M.
- cpu_flush in DATA:
  - transaction finishes on data_ok, FSM goes straight to IDLE, HOLD is never entered.
  - A flush asserted in IDLE with access=1 produces no data_req.
- Reset (rst=0) asserted in ADDR:
  - asynchronously data_req=0, stall=0, cpu_rdata=0, FSM in IDLE.
- With DATA_SRAM_BRIDGE_PERF_EN, three back-to-back loads with 2-cycle stalls each: perf_access_cnt=3, perf_stall_cnt=6.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Purpose: shared constants for the CPU-side SRAM-like memory bridges.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package mips_mem_pkg;

    // Bridge FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Access size codes, shared by the CPU side and the bus side
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Unmapped kernel segments
    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;

    // True when the top three address bits select kseg0 or kseg1
    function automatic logic in_kseg01(input logic [2:0] top3);
        return (top3 == KSEG0_BASE[31:29]) || (top3 == KSEG1_BASE[31:29]);
    endfunction

endpackage

// File: rtl/fixed_addr_map.sv
// Purpose: fixed virtual-to-physical map (kseg0/kseg1 -> low 512 MB, else pass-through).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the input every cycle.
module fixed_addr_map
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PADDR_MAP = 1
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr
);

    logic hit;

    // Clear the segment bits of kseg0/kseg1 addresses when mapping is enabled
    always_comb begin
        hit   = (PADDR_MAP != 0) && in_kseg01(vaddr[ADDR_W-1 -: 3]);
        paddr = vaddr;
        if (hit) begin
            paddr[ADDR_W-1 -: 3] = 3'b000;
        end
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Purpose: M-stage load/store to SRAM-like data bus bridge; optional perf counters via DATA_SRAM_BRIDGE_PERF_EN.
// Latency: request issued in the M cycle itself; best case 2 stall cycles (addr_ok same cycle, data_ok next).
// Backpressure: stallreq_from_mem freezes the pipeline until data_ok; result held while cpu_longest_stall.
module data_sram_bridge
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PADDR_MAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cpu_ren,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_flush,
    input  logic              cpu_longest_stall,
    output logic [31:0]       cpu_rdata,
    output logic              stallreq_from_mem,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
`ifdef DATA_SRAM_BRIDGE_PERF_EN
    ,
    output logic [31:0]       perf_access_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic              access;
    logic              wr_in;
    logic              req_idle;
    logic              kill_now;
    logic [ADDR_W-1:0] paddr_in;

    logic [1:0]        state_q, state_d;
    logic              killed_q, killed_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;

    fixed_addr_map #(
        .ADDR_W    (ADDR_W),
        .PADDR_MAP (PADDR_MAP)
    ) u_map (
        .vaddr (cpu_addr),
        .paddr (paddr_in)
    );

    // Any enabled byte lane is an access; a store wins over a load
    assign access = (|cpu_ren) | (|cpu_wen);
    assign wr_in  = |cpu_wen;

    // New request from IDLE; rst gating keeps the bus quiet while reset is held
    assign req_idle = rst && (state_q == ST_IDLE) && access && !cpu_flush;

    // A flush seen in the current cycle kills the in-flight access as well
    assign kill_now = killed_q | cpu_flush;

    // Next-state, kill tracking, request capture and read-data capture
    always_comb begin
        state_d  = state_q;
        killed_d = killed_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                killed_d = 1'b0;
                if (req_idle) begin
                    addr_d  = paddr_in;
                    wr_d    = wr_in;
                    size_d  = cpu_size;
                    wdata_d = cpu_wdata;
                    state_d = data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Request stays up until accepted, even when flushed
                killed_d = kill_now;
                if (data_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                killed_d = kill_now;
                if (data_data_ok) begin
                    rdata_d = data_rdata;
                    if (kill_now) begin
                        state_d  = ST_IDLE;
                        killed_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!cpu_longest_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            killed_q <= 1'b0;
            rdata_q  <= 32'h0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
        end
    end

    // Bus side: live cpu values in the request cycle, captured copies afterwards
    always_comb begin
        data_req          = req_idle | (state_q == ST_ADDR);
        stallreq_from_mem = req_idle | (state_q == ST_ADDR) | (state_q == ST_DATA);
        data_addr         = req_idle ? paddr_in  : addr_q;
        data_wr           = req_idle ? wr_in     : wr_q;
        data_size         = req_idle ? cpu_size  : size_q;
        data_wdata        = req_idle ? cpu_wdata : wdata_q;
        cpu_rdata         = ((state_q == ST_DATA) && data_data_ok) ? data_rdata : rdata_q;
    end

`ifdef DATA_SRAM_BRIDGE_PERF_EN
    logic [31:0] perf_acc_q, perf_acc_d;
    logic [31:0] perf_stl_q, perf_stl_d;

    // Count completed non-killed accesses and stalled cycles, wrapping at 2^32
    always_comb begin
        perf_acc_d = perf_acc_q;
        perf_stl_d = perf_stl_q;
        if ((state_q == ST_DATA) && data_data_ok && !kill_now) begin
            perf_acc_d = perf_acc_q + 32'd1;
        end
        if (stallreq_from_mem) begin
            perf_stl_d = perf_stl_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_acc_q <= 32'h0;
            perf_stl_q <= 32'h0;
        end else begin
            perf_acc_q <= perf_acc_d;
            perf_stl_q <= perf_stl_d;
        end
    end

    assign perf_access_cnt = perf_acc_q;
    assign perf_stall_cnt  = perf_stl_q;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// Purpose: scoreboard bench for data_sram_bridge (bus requests and load results checked by monitors).
// Latency: n/a.
// Backpressure: bench drives addr_ok/data_ok delays directly.
module tb_data_sram_bridge;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  cpu_ren, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_flush, cpu_longest_stall;
    logic [31:0] cpu_rdata;
    logic        stallreq_from_mem;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
`ifdef DATA_SRAM_BRIDGE_PERF_EN
    logic [31:0] perf_access_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_W(32), .PADDR_MAP(1)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_ren           (cpu_ren),
        .cpu_wen           (cpu_wen),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_size          (cpu_size),
        .cpu_flush         (cpu_flush),
        .cpu_longest_stall (cpu_longest_stall),
        .cpu_rdata         (cpu_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata)
`ifdef DATA_SRAM_BRIDGE_PERF_EN
        ,
        .perf_access_cnt   (perf_access_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        chk;
        logic [31:0] d;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];
    int       n_chk  = 0;
    int       n_pass = 0;
    logic     prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        cpu_ren = 4'h0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        cpu_size = SZ_BYTE; cpu_flush = 1'b0; cpu_longest_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    endtask

    // Monitor: accepted bus requests and pipeline releases against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (data_req && data_addr_ok) begin
                if (exp_bus.size() == 0) begin
                    check("bus_unexpected_req", 32'(data_addr), 32'hFFFF_FFFF);
                end else begin
                    bus_exp_t e;
                    e = exp_bus.pop_front();
                    check("bus_addr",  data_addr,  e.addr);
                    check("bus_wr",    32'(data_wr),   32'(e.wr));
                    check("bus_size",  32'(data_size), 32'(e.size));
                    check("bus_wdata", data_wdata, e.wdata);
                end
            end
            if (prev_stall && !stallreq_from_mem) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected_release", cpu_rdata, 32'hFFFF_FFFF);
                end else begin
                    rsp_exp_t r;
                    r = exp_rsp.pop_front();
                    if (r.chk) check("rsp_rdata", cpu_rdata, r.d);
                end
            end
        end
        prev_stall = rst ? stallreq_from_mem : 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle_in();
        rst = 1'b0;
        repeat (2) nxt();
        smp();
        check("rst_req",   32'(data_req), 32'h0);
        check("rst_stall", 32'(stallreq_from_mem), 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_wr",    32'(data_wr), 32'h0);
        check("rst_addr",  data_addr, 32'h0);
        check("rst_wdata", data_wdata, 32'h0);
        check("rst_size",  32'(data_size), 32'h0);
        nxt(); rst = 1'b1;
        nxt();

        // Word load from kseg0, addr_ok at once, data_ok two cycles later
        cpu_ren = 4'hF; cpu_addr = 32'h8000_1004; cpu_size = SZ_WORD; data_addr_ok = 1'b1;
        exp_bus.push_back('{32'h0000_1004, 1'b0, SZ_WORD, 32'h0});
        exp_rsp.push_back('{1'b1, 32'hDEAD_BEEF});
        smp(); check("t1_stall_c0", 32'(stallreq_from_mem), 32'h1);
        nxt(); data_addr_ok = 1'b0;
        smp(); check("t1_stall_c1", 32'(stallreq_from_mem), 32'h1);
               check("t1_req_c1",   32'(data_req), 32'h0);
        nxt(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        smp(); check("t1_stall_c2", 32'(stallreq_from_mem), 32'h1);
               check("t1_rdata_c2", cpu_rdata, 32'hDEAD_BEEF);
        nxt(); data_data_ok = 1'b0; data_rdata = 32'h0;
        smp(); check("t1_stall_c3", 32'(stallreq_from_mem), 32'h0);
               check("t1_rdata_c3", cpu_rdata, 32'hDEAD_BEEF);
        nxt(); idle_in();

        // Byte store to kseg1, addr_ok held off for three cycles
        cpu_wen = 4'b0100; cpu_addr = 32'hA000_0002; cpu_size = SZ_BYTE; cpu_wdata = 32'h00AB_0000;
        exp_bus.push_back('{32'h0000_0002, 1'b1, SZ_BYTE, 32'h00AB_0000});
        exp_rsp.push_back('{1'b0, 32'h0});
        for (int c = 0; c < 4; c++) begin
            if (c == 3) data_addr_ok = 1'b1;
            smp();
            check("t2_req",   32'(data_req), 32'h1);
            check("t2_addr",  data_addr, 32'h0000_0002);
            check("t2_wr",    32'(data_wr), 32'h1);
            check("t2_stall", 32'(stallreq_from_mem), 32'h1);
            nxt();
            if (c == 0) cpu_addr = 32'h8000_0FF0;
        end
        data_addr_ok = 1'b0;
        smp(); check("t2_stall_data", 32'(stallreq_from_mem), 32'h1);
        nxt(); data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        smp(); check("t2_stall_dok", 32'(stallreq_from_mem), 32'h1);
        nxt(); data_data_ok = 1'b0; data_rdata = 32'h0;
        smp(); check("t2_stall_hold", 32'(stallreq_from_mem), 32'h0);
        nxt(); idle_in();

        // Half load held in HOLD by another stall source for four cycles
        cpu_ren = 4'b0011; cpu_addr = 32'h0000_0100; cpu_size = SZ_HALF; data_addr_ok = 1'b1;
        exp_bus.push_back('{32'h0000_0100, 1'b0, SZ_HALF, 32'h0});
        exp_rsp.push_back('{1'b1, 32'hCAFE_F00D});
        smp();
        nxt(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        smp(); check("t3_stall_dok", 32'(stallreq_from_mem), 32'h1);
        nxt(); data_data_ok = 1'b0; data_rdata = 32'hBAD0_BAD0; cpu_longest_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp();
            check("t3_hold_stall", 32'(stallreq_from_mem), 32'h0);
            check("t3_hold_rdata", cpu_rdata, 32'hCAFE_F00D);
            check("t3_hold_req",   32'(data_req), 32'h0);
            nxt();
            if (c == 3) cpu_longest_stall = 1'b0;
        end
        idle_in();

        // Flush while waiting for data_ok: access completes, HOLD skipped
        cpu_ren = 4'hF; cpu_addr = 32'h8000_0200; cpu_size = SZ_WORD; data_addr_ok = 1'b1;
        exp_bus.push_back('{32'h0000_0200, 1'b0, SZ_WORD, 32'h0});
        exp_rsp.push_back('{1'b0, 32'h0});
        smp();
        nxt(); data_addr_ok = 1'b0; cpu_flush = 1'b1;
        smp(); check("t4_stall_flush", 32'(stallreq_from_mem), 32'h1);
        nxt(); idle_in();
        smp(); check("t4_stall_killed", 32'(stallreq_from_mem), 32'h1);
               check("t4_req_killed",   32'(data_req), 32'h0);
        nxt(); data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        smp(); check("t4_stall_dok", 32'(stallreq_from_mem), 32'h1);
        nxt(); data_data_ok = 1'b0; data_rdata = 32'h0;
        smp(); check("t4_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
               check("t4_stall_after", 32'(stallreq_from_mem), 32'h0);
        nxt();
        smp(); check("t4_state_idle2", 32'(dut.state_q), 32'(ST_IDLE));

        // Flush in IDLE with a pending access issues nothing
        nxt();
        cpu_ren = 4'hF; cpu_addr = 32'h0000_0040; cpu_flush = 1'b1; data_addr_ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
            smp();
            check("t4b_req",   32'(data_req), 32'h0);
            check("t4b_stall", 32'(stallreq_from_mem), 32'h0);
            nxt();
        end
        idle_in();

        // Asynchronous reset while waiting for addr_ok
        cpu_ren = 4'hF; cpu_addr = 32'h0000_1000; cpu_size = SZ_WORD;
        smp(); check("t5_req_c0", 32'(data_req), 32'h1);
        nxt();
        smp(); check("t5_req_addr",   32'(data_req), 32'h1);
               check("t5_stall_addr", 32'(stallreq_from_mem), 32'h1);
        #2; rst = 1'b0; idle_in();
        #1;
        check("t5_rst_req",   32'(data_req), 32'h0);
        check("t5_rst_stall", 32'(stallreq_from_mem), 32'h0);
        check("t5_rst_rdata", cpu_rdata, 32'h0);
        check("t5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        nxt(); nxt(); rst = 1'b1;
        nxt();

        // Three back-to-back best-case loads
        for (int k = 0; k < 3; k++) begin
            logic [31:0] val;
            val = 32'h1111_1111 * (k + 1);
            idle_in();
            cpu_ren = 4'hF; cpu_addr = 32'h8000_0000 + 32'(k * 4); cpu_size = SZ_WORD;
            data_addr_ok = 1'b1;
            exp_bus.push_back('{32'(k * 4), 1'b0, SZ_WORD, 32'h0});
            exp_rsp.push_back('{1'b1, val});
            smp();
            nxt(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = val;
            smp();
            nxt(); data_data_ok = 1'b0; data_rdata = 32'h0;
            smp(); check("t6_hold_stall", 32'(stallreq_from_mem), 32'h0);
            nxt();
        end
        idle_in();
        smp();
`ifdef DATA_SRAM_BRIDGE_PERF_EN
        check("perf_access", perf_access_cnt, 32'd3);
        check("perf_stall",  perf_stall_cnt,  32'd6);
`endif
        check("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
